// File: rtl/gan_core_sched_if.sv
// Bus bundle for the GAN core scheduler: two requester ports, the shared-core drive
// and return path, and the response port.
interface gan_core_sched_if #(
    parameter int WIDTH = 32
);
    logic                 req0_valid;
    logic                 req1_valid;
    logic                 req0_ready;
    logic                 req1_ready;
    logic                 req0_choice;
    logic                 req1_choice;
    logic [WIDTH-1:0]     req0_in_1;
    logic [WIDTH-1:0]     req0_in_2;
    logic [WIDTH-1:0]     req1_in_1;
    logic [WIDTH-1:0]     req1_in_2;

    logic                 core_choice;
    logic [WIDTH-1:0]     core_in_1;
    logic [WIDTH-1:0]     core_in_2;
    logic [WIDTH-1:0]     core_out_discriminator;
    logic [9*WIDTH-1:0]   core_pixels;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [WIDTH-1:0]     rsp_discriminator;
    logic [9*WIDTH-1:0]   rsp_pixels;

    // Master is the environment (requesters, core, response sink); slave is the scheduler.
    modport master (
        output req0_valid, req1_valid, req0_choice, req1_choice,
        output req0_in_1, req0_in_2, req1_in_1, req1_in_2,
        input  req0_ready, req1_ready,
        input  core_choice, core_in_1, core_in_2,
        output core_out_discriminator, core_pixels,
        input  rsp_valid, rsp_id, rsp_discriminator, rsp_pixels,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req1_valid, req0_choice, req1_choice,
        input  req0_in_1, req0_in_2, req1_in_1, req1_in_2,
        output req0_ready, req1_ready,
        output core_choice, core_in_1, core_in_2,
        input  core_out_discriminator, core_pixels,
        output rsp_valid, rsp_id, rsp_discriminator, rsp_pixels,
        input  rsp_ready
    );
endinterface

// File: rtl/gan_core_sched.sv
// Round-robin scheduler sharing one fixed-latency generator/discriminator core
// between two requesters; one operation in flight at a time.
module gan_core_sched #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    gan_core_sched_if.slave  bus
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [3:0]           count;
    logic                 last_grant;
    logic                 grant_any;
    logic                 grant_id;

    logic                 core_choice_q;
    logic [WIDTH-1:0]     core_in_1_q;
    logic [WIDTH-1:0]     core_in_2_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [WIDTH-1:0]     rsp_disc_q;
    logic [9*WIDTH-1:0]   rsp_pixels_q;

    assign bus.core_choice       = core_choice_q;
    assign bus.core_in_1         = core_in_1_q;
    assign bus.core_in_2         = core_in_2_q;
    assign bus.rsp_valid         = rsp_valid_q;
    assign bus.rsp_id            = rsp_id_q;
    assign bus.rsp_discriminator = rsp_disc_q;
    assign bus.rsp_pixels        = rsp_pixels_q;

    // Grants only in IDLE and never while reset is asserted; on contention the
    // requester that did not win last time is favoured.
    always_comb begin
        state_nxt      = state;
        grant_any      = 1'b0;
        grant_id       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && (bus.req0_valid || bus.req1_valid)) begin
                    grant_any = 1'b1;
                    if (bus.req0_valid && bus.req1_valid)
                        grant_id = ~last_grant;
                    else
                        grant_id = bus.req1_valid;
                    bus.req0_ready = ~grant_id;
                    bus.req1_ready = grant_id;
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd1)
                    state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Core operands are latched at grant and held until the next grant; the core
    // result is sampled on the last WAIT cycle and frozen until the response drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 4'd0;
            last_grant    <= 1'b1;
            core_choice_q <= 1'b0;
            core_in_1_q   <= '0;
            core_in_2_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_disc_q    <= '0;
            rsp_pixels_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        core_choice_q <= grant_id ? bus.req1_choice : bus.req0_choice;
                        core_in_1_q   <= grant_id ? bus.req1_in_1   : bus.req0_in_1;
                        core_in_2_q   <= grant_id ? bus.req1_in_2   : bus.req0_in_2;
                        rsp_id_q      <= grant_id;
                        last_grant    <= grant_id;
                        count         <= LAT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        rsp_disc_q   <= bus.core_out_discriminator;
                        rsp_pixels_q <= bus.core_pixels;
                        rsp_valid_q  <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready)
                        rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gan_core_sched.sv
// Directed self-checking bench for gan_core_sched at LATENCY 2, plus LATENCY 1 and 15
// instances used for response timing.
module tb_gan_core_sched;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   total_checks;
    int   bad_checks;

    gan_core_sched_if #(.WIDTH(W)) bus   ();
    gan_core_sched_if #(.WIDTH(W)) bus1  ();
    gan_core_sched_if #(.WIDTH(W)) bus15 ();

    gan_core_sched #(.WIDTH(W), .LATENCY(2))  dut    (.clk(clk), .rst(rst), .bus(bus));
    gan_core_sched #(.WIDTH(W), .LATENCY(1))  u_lat1 (.clk(clk), .rst(rst), .bus(bus1));
    gan_core_sched #(.WIDTH(W), .LATENCY(15)) u_lat15(.clk(clk), .rst(rst), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int which, input logic ch, input logic [W-1:0] a, input logic [W-1:0] b);
        if (which == 0) begin
            bus.req0_valid  = 1'b1;
            bus.req0_choice = ch;
            bus.req0_in_1   = a;
            bus.req0_in_2   = b;
        end else begin
            bus.req1_valid  = 1'b1;
            bus.req1_choice = ch;
            bus.req1_in_1   = a;
            bus.req1_in_2   = b;
        end
        #1;
    endtask

    initial begin
        int n;
        int g1;
        int g15;
        int grants[$];
        int gcyc[$];
        int rids[$];
        logic [W-1:0] k_val;

        total_checks = 0;
        bad_checks   = 0;
        rst = 1'b1;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_choice = 0; bus.req1_choice = 0;
        bus.req0_in_1 = '0; bus.req0_in_2 = '0; bus.req1_in_1 = '0; bus.req1_in_2 = '0;
        bus.core_out_discriminator = '0; bus.core_pixels = '0; bus.rsp_ready = 0;
        bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.req0_choice = 0; bus1.req1_choice = 0;
        bus1.req0_in_1 = '0; bus1.req0_in_2 = '0; bus1.req1_in_1 = '0; bus1.req1_in_2 = '0;
        bus1.core_out_discriminator = '0; bus1.core_pixels = '0; bus1.rsp_ready = 1;
        bus15.req0_valid = 0; bus15.req1_valid = 0; bus15.req0_choice = 0; bus15.req1_choice = 0;
        bus15.req0_in_1 = '0; bus15.req0_in_2 = '0; bus15.req1_in_1 = '0; bus15.req1_in_2 = '0;
        bus15.core_out_discriminator = '0; bus15.core_pixels = '0; bus15.rsp_ready = 1;

        // Reset state, and no ready while reset is held even with both requesters valid
        tick(); tick();
        bus.req0_valid = 1; bus.req1_valid = 1; #1;
        checkOutput("rst_ready0", bus.req0_ready, 0);
        checkOutput("rst_ready1", bus.req1_ready, 0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_rsp_id", bus.rsp_id, 0);
        checkOutput("rst_core_choice", bus.core_choice, 0);
        checkOutput("rst_core_in_1", bus.core_in_1, 0);
        checkOutput("rst_rsp_disc", bus.rsp_discriminator, 0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick();
        rst = 1'b0;

        // Single request from req0, with a known discriminator and pixel pattern
        bus.core_out_discriminator = 32'h0080_0000;
        for (int k = 1; k <= 9; k++) bus.core_pixels[(k-1)*W +: W] = W'(k) * 32'h0100_0000;
        applyStimulus(0, 1'b0, 32'h0000_0000, 32'h0100_0000);
        checkOutput("single_ready0", bus.req0_ready, 1);
        checkOutput("single_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 0;
        checkOutput("single_core_in_2", bus.core_in_2, 32'h0100_0000);
        checkOutput("single_core_choice", bus.core_choice, 0);
        n = 1;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; end
        checkOutput("single_latency", n, 3);
        checkOutput("single_rsp_id", bus.rsp_id, 0);
        checkOutput("single_rsp_disc", bus.rsp_discriminator, 32'h0080_0000);
        for (int k = 1; k <= 9; k++) begin
            k_val = W'(k) * 32'h0100_0000;
            checkOutput($sformatf("pixel_%0d", k), bus.rsp_pixels[(k-1)*W +: W], k_val);
        end
        bus.rsp_ready = 1;
        tick();
        bus.rsp_ready = 0;
        checkOutput("single_done", bus.rsp_valid, 0);

        // Backpressure: response from req1 must hold while core outputs move
        bus.core_out_discriminator = 32'hAAAA_0001;
        applyStimulus(1, 1'b1, 32'h1234_5678, 32'hFEDC_BA98);
        checkOutput("bp_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 0;
        n = 1;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; end
        checkOutput("bp_latency", n, 3);
        for (int c = 0; c < 5; c++) begin
            bus.core_out_discriminator = 32'h5555_0000 + 32'(c);
            bus.core_pixels[W-1:0] = 32'h7777_0000 + 32'(c);
            bus.req0_valid = 1;
            #1;
            checkOutput("bp_valid", bus.rsp_valid, 1);
            checkOutput("bp_disc", bus.rsp_discriminator, 32'hAAAA_0001);
            checkOutput("bp_pix1", bus.rsp_pixels[W-1:0], 32'h0100_0000);
            checkOutput("bp_id", bus.rsp_id, 1);
            checkOutput("bp_ready0", bus.req0_ready, 0);
            tick();
        end
        bus.rsp_ready = 1; #1;
        checkOutput("bp_complete_ready0", bus.req0_ready, 0);
        tick();
        bus.req0_valid = 0; bus.rsp_ready = 0;
        checkOutput("bp_done", bus.rsp_valid, 0);
        checkOutput("bp_core_hold_in_1", bus.core_in_1, 32'h1234_5678);
        checkOutput("bp_core_hold_choice", bus.core_choice, 1);

        // Reset mid-WAIT: req0 won last, so only reset makes req0 win the next contention
        tick();
        applyStimulus(1, 1'b1, 32'h0BAD_F00D, 32'h0000_0001);
        bus.req1_valid = 0;
        applyStimulus(0, 1'b1, 32'h0BAD_F00D, 32'h0000_0001);
        checkOutput("mid_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        checkOutput("mid_rsp_valid", bus.rsp_valid, 0);
        checkOutput("mid_core_in_1", bus.core_in_1, 0);
        checkOutput("mid_core_choice", bus.core_choice, 0);
        checkOutput("mid_rsp_disc", bus.rsp_discriminator, 0);
        tick(); tick(); tick();
        checkOutput("mid_no_rsp", bus.rsp_valid, 0);

        // Contention: both valid, sink always ready; grants must alternate 4 cycles apart
        bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp_ready = 1; #1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (bus.req0_ready && bus.req1_ready) checkOutput("cont_both_ready", 1, 0);
            else if (bus.req0_ready) begin grants.push_back(0); gcyc.push_back(cyc); end
            else if (bus.req1_ready) begin grants.push_back(1); gcyc.push_back(cyc); end
            if (bus.rsp_valid) rids.push_back(int'(bus.rsp_id));
            tick();
        end
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 0;
        checkOutput("cont_num_grants", grants.size() >= 4, 1);
        checkOutput("cont_num_rsps", rids.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) checkOutput($sformatf("cont_grant_%0d", i), grants[i], i % 2);
            if (i < rids.size())   checkOutput($sformatf("cont_rsp_id_%0d", i), rids[i], i % 2);
            if (i > 0 && i < gcyc.size())
                checkOutput($sformatf("cont_spacing_%0d", i), gcyc[i] - gcyc[i-1], 4);
        end

        // Latency extremes: rsp_valid at grant+2 for LATENCY 1 and grant+16 for LATENCY 15
        bus1.req0_valid = 1; bus15.req0_valid = 1; #1;
        checkOutput("lat1_ready0", bus1.req0_ready, 1);
        checkOutput("lat15_ready0", bus15.req0_ready, 1);
        tick();
        bus1.req0_valid = 0; bus15.req0_valid = 0;
        g1 = 0; g15 = 0;
        for (int i = 1; i <= 30; i++) begin
            if (bus1.rsp_valid && g1 == 0) g1 = i;
            if (bus15.rsp_valid && g15 == 0) g15 = i;
            tick();
        end
        checkOutput("lat1_latency", g1, 2);
        checkOutput("lat15_latency", g15, 16);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end
endmodule

// File: doc/gan_core_sched.md
GAN_CORE_SCHED -- requirements
Module: gan_core_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of all operands and results (Q8.24 signed).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from core input change to valid core outputs; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-006 SHALL have ports req0_ready, req1_ready  output  1 each  grant/accept strobe to the requester.
REQ-007 SHALL have ports req0_choice, req1_choice  input  1 each  mode select passed to the core.
REQ-008 SHALL have ports req0_in_1, req0_in_2, req1_in_1, req1_in_2  input  WIDTH each  signed operands.
REQ-009 SHALL have ports core_choice (1), core_in_1 (WIDTH), core_in_2 (WIDTH)  output  registered drive to the shared generator/discriminator core.
REQ-010 SHALL have port core_out_discriminator  input  WIDTH  core discriminator result.
REQ-011 SHALL have port core_pixels  input  9*WIDTH  core pixels; pixel_1x1 in bits [WIDTH-1:0], then row-major up to pixel_3x3 in the top slice.
REQ-012 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_id output 1 (granted requester index).
REQ-013 SHALL have ports rsp_discriminator  output  WIDTH, and rsp_pixels  output  9*WIDTH (same packing as core_pixels).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 SHALL, in IDLE, combinationally assert exactly one reqN_ready when any reqN_valid is high; never in WAIT or RESP.
REQ-016 SHALL arbitrate round-robin: when both valid, grant the requester not granted last; last_grant resets to 1 so req0 wins the first contention.
REQ-017 SHALL, on the edge ending a grant cycle, register the granted choice/in_1/in_2 into core_*, set rsp_id, load counter with LATENCY, and enter WAIT.
REQ-018 SHALL hold core_* stable from grant until the next grant.
REQ-019 SHALL decrement the counter each WAIT cycle; on the edge where counter equals 1, capture core_out_discriminator and core_pixels into rsp_* registers, set rsp_valid, enter RESP.
REQ-020 SHALL thus raise rsp_valid exactly LATENCY+1 cycles after the grant cycle.
REQ-021 SHALL, in RESP, hold rsp_valid and all rsp_* stable until rsp_ready is sampled high, then clear rsp_valid and enter IDLE.
REQ-022 SHALL not accept a new request in the cycle rsp_ready completes a response; minimum spacing between grants is LATENCY+2 cycles.
REQ-023 SHALL pass data unmodified (no arithmetic, saturation or sign change).
REQ-024 SHALL ignore reqN_valid changes and operand changes outside the grant cycle.

Reset
REQ-025 SHALL, while rst is high on a clock edge, force state IDLE, counter 0, last_grant 1, rsp_valid 0, rsp_id 0, rsp_* data 0, core_choice 0, core_in_1/core_in_2 0.
REQ-026 SHALL hold req0_ready and req1_ready at 0 during any cycle where rst is high.
REQ-027 SHALL abort any in-flight operation on reset mid-WAIT or mid-RESP, without emitting its response.

Verification
REQ-028 Single request: req0 in_1=0x00000000, in_2=0x01000000, choice=0; core model returns disc=0x00800000 after LATENCY=2 -> req0_ready one cycle, rsp_valid 3 cycles later, rsp_id=0, rsp_discriminator=0x00800000.
REQ-029 Contention: both valid continuously from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; grants 4 cycles apart.
REQ-030 Backpressure: rsp_ready=0 for 5 cycles in RESP with core outputs changing -> rsp_* unchanged, no readyN asserted, completes on first rsp_ready=1.
REQ-031 Pixel packing: core_pixels set to pixel k = k*0x01000000 (k=1..9) -> rsp_pixels slice k-1 equals the same value.
REQ-032 Reset mid-WAIT: rst pulsed one cycle during WAIT -> all outputs 0 next cycle, no rsp_valid, next contention grants req0.
REQ-033 LATENCY=1 and LATENCY=15 builds -> rsp_valid at grant+2 and grant+16 respectively.
